pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 9, SHALL set the width of the control bundle (WriteReg, MemToReg, writeMem, Branch, Regrt, ALUC[2:0], ALUimm).
REQ-002 Parameter DATA_W, default 106, SHALL set the width of the data bundle (nextAddress, R1, R2, signExtend, rd, rt).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the stall counter.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 in_valid  in  1  SHALL indicate the upstream stage presents an instruction.
REQ-007 in_ready  out  1  SHALL indicate this stage accepts the instruction this cycle.
REQ-008 in_ctrl  in  CTRL_W  SHALL carry the upstream control bundle.
REQ-009 in_data  in  DATA_W  SHALL carry the upstream data bundle.
REQ-010 flush  in  1  SHALL request that all held instructions be squashed.
REQ-011 out_valid  out  1  SHALL indicate an instruction is presented downstream.
REQ-012 out_ready  in  1  SHALL indicate the downstream stage consumes the instruction.
REQ-013 out_ctrl  out  CTRL_W  SHALL be the downstream control bundle.
REQ-014 out_data  out  DATA_W  SHALL be the downstream data bundle.
REQ-015 occupancy  out  2  SHALL report held entries (0, 1 or 2).
REQ-016 stall_cnt  out  CNT_W  SHALL count cycles with out_valid=1 and out_ready=0.

Function
REQ-017 The stage SHALL hold two entries: main (drives outputs) and skid; each entry is a valid bit, ctrl and data.
REQ-018 in_ready SHALL equal NOT skid.valid, driven from a register with no combinational path from out_ready.
REQ-019 An input transfer SHALL occur when in_valid=1 and in_ready=1; an output transfer when out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL equal main.valid; out_data SHALL equal main.data.
REQ-021 out_ctrl SHALL equal main.ctrl when main.valid=1 and all-zero otherwise, so that a bubble never asserts a write enable.
REQ-022 Latency SHALL be one cycle: an input accepted into an empty stage appears on out_* the next cycle.
REQ-023 If main is empty, or is emptied by an output transfer in the same cycle, the stage SHALL load main from skid when skid.valid=1, else from the accepted input.
REQ-024 If skid moves to main and an input transfer occurs in the same cycle, the accepted input SHALL load skid.
REQ-025 If main is valid with no output transfer and an input transfer occurs, the input SHALL load skid.
REQ-026 Order SHALL be preserved: no entry is dropped or duplicated, and skid always holds the younger entry.
REQ-027 With occupancy=2 and out_ready=1 held, throughput SHALL be one instruction per cycle from the following cycle.
REQ-028 flush=1 SHALL clear main.valid and skid.valid at the next edge and discard any same-cycle input transfer.
REQ-029 flush SHALL take priority over every transfer; rst SHALL take priority over flush.
REQ-030 stall_cnt SHALL increment by one per qualifying cycle and saturate at all-ones; it SHALL NOT be cleared by flush.
REQ-031 occupancy SHALL equal main.valid + skid.valid.

Reset
REQ-032 When rst=1 at a rising edge, both valid bits, all ctrl and data registers, and stall_cnt SHALL be zero.
REQ-033 The reset-state outputs SHALL be: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, and in_ready=1 from the first cycle after reset.
REQ-034 Reset asserted mid-transfer SHALL discard all held and incoming entries with no partial update.

Structure
REQ-035 The package pipe_pkg SHALL hold the CTRL_W/DATA_W defaults and the bit offsets of each ID/EXE control and data field.
REQ-036 Each entry SHALL be an instance of the sub-module pipe_entry: a valid+ctrl+data register with load and clear inputs.

Verification
REQ-037 The bench SHALL apply rst, then in_valid=1 with ctrl=9'h1FF, data=A, and out_ready=1; out_valid=1 with out_ctrl=9'h1FF and out_data=A SHALL appear exactly one cycle later.
REQ-038 The bench SHALL hold out_ready=0 while pushing A then B; the required response is occupancy=2 and in_ready=0; on releasing out_ready, A then B SHALL appear on consecutive cycles.
REQ-039 The bench SHALL assert flush with occupancy=2 and in_valid=1 carrying C; the next cycle SHALL show out_valid=0, out_ctrl=0, occupancy=0, and C SHALL never appear.
REQ-040 The bench SHALL hold out_valid=1 with out_ready=0 for 2^CNT_W+3 cycles using CNT_W=4; stall_cnt SHALL saturate at 15.
REQ-041 The bench SHALL assert rst while occupancy=2, flush=1 and in_valid=1; all outputs SHALL be zero, in_ready=1 SHALL hold the next cycle, and stall_cnt=0.
REQ-042 The bench SHALL run 10,000 cycles with random valid/ready and sparse flush against a queue model; the output order SHALL match with no loss and no duplication.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and ID/EXE field offsets for the skid-buffered pipeline register.
package pipe_pkg;
  localparam int CTRL_W_DEF = 9;
  localparam int DATA_W_DEF = 106;
  localparam int CNT_W_DEF  = 16;

  // Control bundle, MSB first: WriteReg MemToReg writeMem Branch Regrt ALUC[2:0] ALUimm
  localparam int WRITEREG_BIT = 8;
  localparam int MEMTOREG_BIT = 7;
  localparam int WRITEMEM_BIT = 6;
  localparam int BRANCH_BIT   = 5;
  localparam int REGRT_BIT    = 4;
  localparam int ALUC_LSB     = 1;
  localparam int ALUC_W       = 3;
  localparam int ALUIMM_BIT   = 0;

  // Data bundle, MSB first: nextAddress[31:0] R1[15:0] R2[15:0] signExtend[31:0] rd[4:0] rt[4:0]
  localparam int NEXTADDR_LSB = 74;
  localparam int NEXTADDR_W   = 32;
  localparam int R1_LSB       = 58;
  localparam int R1_W         = 16;
  localparam int R2_LSB       = 42;
  localparam int R2_W         = 16;
  localparam int SIGNEXT_LSB  = 10;
  localparam int SIGNEXT_W    = 32;
  localparam int RD_LSB       = 5;
  localparam int RD_W         = 5;
  localparam int RT_LSB       = 0;
  localparam int RT_W         = 5;
endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid bit plus control and data payload, with load and clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear only drops the valid bit; payload is don't-care while invalid.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// ID/EXE pipeline register with a skid slot so in_ready is registered and never sees out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              in_xfer, out_xfer;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_ready = ~skid_valid;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    main_ctrl_in = in_ctrl;
    main_data_in = in_data;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid || out_xfer) begin
      if (skid_valid) begin
        // Skid is the older of skid/input, so it always moves up first.
        main_load    = 1'b1;
        main_ctrl_in = skid_ctrl;
        main_data_in = skid_data;
        skid_load    = in_xfer;
        skid_clear   = ~in_xfer;
      end else if (in_xfer) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (in_xfer) begin
      skid_load = 1'b1;
    end
  end

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  // Bubbles present an all-zero control word so no write enable leaks downstream.
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of the skid pipeline stage against hand values and a queue model.
module tb_pipe_stage_skid;
  localparam int CW = 9;
  localparam int DW = 106;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [DW-1:0] DA = 106'h1_2345_6789_ABCD_EF01_2345_6789;
  localparam logic [DW-1:0] DB = 106'h3_FEDC_BA98_7654_3210_0F0F_F0F0;
  localparam logic [DW-1:0] DC = 106'h0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
  localparam logic [DW-1:0] DD = 106'h2_DDDD_0000_DDDD_0000_DDDD_0000;

  typedef logic [CW+DW-1:0] ent_t;
  ent_t q[$];

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, 128'(out_valid), 128'(0));
    check({tag, " out_ctrl"},  128'(out_ctrl),  128'(0));
    check({tag, " occupancy"}, 128'(occupancy), 128'(0));
    check({tag, " in_ready"},  128'(in_ready),  128'(1));
  endtask

  initial begin
    int sz;
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check_idle("reset");
    check("reset out_data", 128'(out_data), 128'(0));
    check("reset stall_cnt", 128'(stall_cnt), 128'(0));

    // one-cycle latency
    in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = DA; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat out_valid", 128'(out_valid), 128'(1));
    check("lat out_ctrl", 128'(out_ctrl), 128'(9'h1FF));
    check("lat out_data", 128'(out_data), 128'(DA));
    step();
    check_idle("lat drain");

    // backpressure fills skid, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 9'h0A5; in_data = DA;
    step();
    check("bp occ1", 128'(occupancy), 128'(1));
    check("bp ready1", 128'(in_ready), 128'(1));
    in_ctrl = 9'h15A; in_data = DB;
    step();
    in_valid = 1'b0;
    check("bp occ2", 128'(occupancy), 128'(2));
    check("bp ready0", 128'(in_ready), 128'(0));
    check("bp head", 128'(out_data), 128'(DA));
    step();
    check("bp hold occ", 128'(occupancy), 128'(2));
    check("bp hold data", 128'(out_data), 128'(DA));
    out_ready = 1'b1;
    step();
    check("bp B data", 128'(out_data), 128'(DB));
    check("bp B ctrl", 128'(out_ctrl), 128'(9'h15A));
    check("bp B valid", 128'(out_valid), 128'(1));
    check("bp B occ", 128'(occupancy), 128'(1));
    step();
    check_idle("bp drain");

    // flush at full occupancy with pending input C
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = DA;
    step();
    in_data = DB;
    step();
    check("fl occ2", 128'(occupancy), 128'(2));
    flush = 1'b1; in_data = DC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush full");
    out_ready = 1'b1;
    step();
    check("fl noC valid", 128'(out_valid), 128'(0));
    // flush with room: same-cycle accepted input must also be dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 9'h101; in_data = DD;
    step();
    flush = 1'b1; in_data = DC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush occ1");
    step();
    check("fl noC later", 128'(out_valid), 128'(0));

    // stall counter saturation, from a clean reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 9'h011; in_data = DD; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("sat start", 128'(stall_cnt), 128'(0));
    repeat (14) step();
    check("sat 14", 128'(stall_cnt), 128'(14));
    repeat (5) step();
    check("sat 15", 128'(stall_cnt), 128'(15));
    check("sat data held", 128'(out_data), 128'(DD));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat flush keeps", 128'(stall_cnt), 128'(15));

    // reset beats flush and input at full occupancy
    in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = DA;
    step();
    in_data = DB;
    step();
    check("rst occ2", 128'(occupancy), 128'(2));
    rst = 1'b1; flush = 1'b1; in_data = DC;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_idle("rst mid");
    check("rst mid data", 128'(out_data), 128'(0));
    check("rst mid stall", 128'(stall_cnt), 128'(0));
    step();
    check("rst next ready", 128'(in_ready), 128'(1));
    check("rst next valid", 128'(out_valid), 128'(0));

    // random traffic against a queue model
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      sz = q.size();
      check("rnd occ", 128'(occupancy), 128'(sz));
      check("rnd in_ready", 128'(in_ready), 128'(sz < 2));
      check("rnd out_valid", 128'(out_valid), 128'(sz > 0));
      if (sz > 0) check("rnd head", 128'({out_ctrl, out_data}), 128'(q[0]));
      else        check("rnd bubble ctrl", 128'(out_ctrl), 128'(0));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = DW'({$urandom, $urandom, $urandom, $urandom});
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && sz > 0) void'(q.pop_front());
        if (in_valid && sz < 2) q.push_back({in_ctrl, in_data});
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
